// File: rtl/seg7_pkg.sv
// Shared types, constants and segment decoder for the 3-digit counter display.
// Segment vectors are active-low, bit 0 = a ... bit 6 = g.
package seg7_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_UPDATE
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [2:0] SEG_OFF_AN = 3'b111;

  // Active-low glyph for one BCD nibble; non-decimal codes show nothing.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to three BCD digits, one
// add-3-then-shift step per clock. done pulses for one clock while bcd is valid.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk50m,
  input  logic        rs,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state;
  logic [19:0] sh;
  logic [3:0]  bit_cnt;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] a;
    a = v;
    for (int i = 0; i < 3; i++) begin
      if (a[8 + 4*i +: 4] >= 4'd5)
        a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  // Converter FSM with its shift datapath; done is registered on the last shift.
  always_ff @(posedge clk50m or negedge rs) begin
    if (!rs) begin
      state   <= S_IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sh      <= {12'd0, bin};
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sh      <= dabble_step(sh);
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            state <= S_UPDATE;
            done  <= 1'b1;
          end
        end
        S_UPDATE: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bcd = sh[19:8];

endmodule

// File: rtl/seg7_count_display.sv
// Counter display stage: watches dem8_bit, reconverts it to BCD whenever it
// differs from the last converted value, and scans three common-anode digits.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000
)(
  input  logic       clk50m,
  input  logic       rs,
  input  logic [7:0] dem8_bit,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [7:0]       last_bin;
  logic [7:0]       cap_bin;
  logic [2:0][3:0]  dig;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic             start;
  logic             done;
  logic [11:0]      bcd;
  logic [3:0]       cur_dig;
  logic             cur_blank;

  // A new conversion is only requested while the converter is idle; busy
  // tracks the converter's non-idle span (set on start, cleared on done).
  assign start = !busy && (dem8_bit != last_bin);

  bin2bcd_seq u_conv (
    .clk50m (clk50m),
    .rs     (rs),
    .start  (start),
    .bin    (dem8_bit),
    .done   (done),
    .bcd    (bcd)
  );

  // Capture the value being converted and commit digits when the converter finishes.
  always_ff @(posedge clk50m or negedge rs) begin
    if (!rs) begin
      busy     <= 1'b0;
      last_bin <= '0;
      cap_bin  <= '0;
      dig      <= '0;
    end else if (done) begin
      dig      <= bcd;
      last_bin <= cap_bin;
      busy     <= 1'b0;
    end else if (start) begin
      cap_bin <= dem8_bit;
      busy    <= 1'b1;
    end
  end

  // Scan divider and digit slot; an out-of-range slot recovers to units.
  always_ff @(posedge clk50m or negedge rs) begin
    if (!rs) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else begin
      if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + 1'b1;

      if (idx == 2'd3)
        idx <= 2'd0;
      else if (div_cnt == DIV_LAST)
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

  // Select the nibble for the current slot and decide whether it is blanked.
  always_comb begin
    cur_dig   = 4'd0;
    cur_blank = 1'b0;
    case (idx)
      2'd0: cur_dig = dig[0];
      2'd1: begin
        cur_dig = dig[1];
`ifdef LEADING_ZERO_BLANK_EN
        cur_blank = (dig[2] == 4'd0) && (dig[1] == 4'd0);
`endif
      end
      2'd2: begin
        cur_dig = dig[2];
`ifdef LEADING_ZERO_BLANK_EN
        cur_blank = (dig[2] == 4'd0);
`endif
      end
      default: cur_blank = 1'b1;
    endcase
  end

  // Registered display drive, refreshed every clock.
  always_ff @(posedge clk50m or negedge rs) begin
    if (!rs) begin
      seg <= SEG_BLANK;
      an  <= SEG_OFF_AN;
    end else begin
      an  <= (idx == 2'd3) ? SEG_OFF_AN : ~(3'b001 << idx);
      seg <= cur_blank ? SEG_BLANK : bcd_to_seg(cur_dig);
    end
  end

endmodule

// File: tb/tb_seg7_count_display.sv
// Self-checking bench for seg7_count_display: directed steps plus random
// values, compared against decimal digits computed with plain arithmetic.
module tb_seg7_count_display;

  localparam int SCAN_DIV = 4;

  logic       clk50m = 1'b0;
  logic       rs;
  logic [7:0] dem8_bit;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  seg7_count_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk50m   (clk50m),
    .rs       (rs),
    .dem8_bit (dem8_bit),
    .seg      (seg),
    .an       (an),
    .busy     (busy)
  );

  always #5 clk50m = ~clk50m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk50m);
      #1;
    end
  endtask

  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected segments for position pos (0 units, 1 tens, 2 hundreds) of value v.
  function automatic logic [6:0] exp_seg(input int v, input int pos);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos == 2 && h == 0) return 7'h7F;
    if (pos == 1 && h == 0 && t == 0) return 7'h7F;
`endif
    case (pos)
      0:       return ref_glyph(u);
      1:       return ref_glyph(t);
      default: return ref_glyph(h);
    endcase
  endfunction

  function automatic logic [11:0] exp_dig(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] exp_an(input int slot);
    logic [2:0] a;
    a = ~(3'b001 << slot);
    return a;
  endfunction

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (busy && guard < 40) begin
      tick(1);
      guard++;
    end
    check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  // Apply a new value and check busy span and committed digits.
  task automatic convert(input logic [7:0] v, input string tag);
    int hi;
    int guard;
    hi = 0;
    guard = 0;
    dem8_bit = v;
    tick(1);
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    while (busy && guard < 40) begin
      hi++;
      tick(1);
      guard++;
    end
    check({tag, "_busy_len"}, 32'(hi), 32'd9);
    check({tag, "_dig"}, 32'(dut.dig), 32'(exp_dig(int'(v))));
  endtask

  // Observe one full scan and compare every digit's segments.
  task automatic check_display(input int v, input string tag);
    logic [6:0] s [3];
    for (int k = 0; k < 3; k++) s[k] = 'x;
    for (int c = 0; c < 3 * SCAN_DIV; c++) begin
      case (an)
        3'b110:  s[0] = seg;
        3'b101:  s[1] = seg;
        3'b011:  s[2] = seg;
        default: ;
      endcase
      tick(1);
    end
    check({tag, "_seg_units"}, 32'(s[0]), 32'(exp_seg(v, 0)));
    check({tag, "_seg_tens"},  32'(s[1]), 32'(exp_seg(v, 1)));
    check({tag, "_seg_hund"},  32'(s[2]), 32'(exp_seg(v, 2)));
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] v;
    int guard;
    int cvals [4];

    rs = 1'b0;
    dem8_bit = 8'd0;
    tick(3);
    check("rst_seg",  32'(seg),     32'h7F);
    check("rst_an",   32'(an),      32'b111);
    check("rst_busy", 32'(busy),    32'd0);
    check("rst_dig",  32'(dut.dig), 32'd0);

    // Scan pattern after release: each slot lasts SCAN_DIV clocks.
    rs = 1'b1;
    for (int i = 1; i <= 3 * SCAN_DIV; i++) begin
      int slot;
      tick(1);
      slot = ((i - 1) / SCAN_DIV) % 3;
      check($sformatf("scan_an_%0d", i),  32'(an),  32'(exp_an(slot)));
      check($sformatf("scan_seg_%0d", i), 32'(seg), 32'(exp_seg(0, slot)));
      check($sformatf("scan_busy_%0d", i), 32'(busy), 32'd0);
    end

    convert(8'd255, "v255");
    check_display(255, "v255");
    convert(8'd7, "v7");
    check_display(7, "v7");
    convert(8'd0, "v0");
    check_display(0, "v0");

    // Input change during the third busy cycle is picked up afterwards.
    dem8_bit = 8'd100;
    tick(1);
    check("chg_busy1", 32'(busy), 32'd1);
    tick(2);
    dem8_bit = 8'd101;
    guard = 0;
    while (busy && guard < 40) begin
      tick(1);
      guard++;
    end
    check("chg_first_idle", 32'(busy), 32'd0);
    check("chg_first_dig", 32'(dut.dig), 32'(exp_dig(100)));
    tick(1);
    check("chg_second_start", 32'(busy), 32'd1);
    wait_idle("chg_second");
    check("chg_second_dig", 32'(dut.dig), 32'(exp_dig(101)));
    check_display(101, "v101");

    // Reset pulse in the middle of converting 200.
    dem8_bit = 8'd200;
    tick(4);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2;
    rs = 1'b0;
    #1;
    check("abort_seg",  32'(seg),     32'h7F);
    check("abort_an",   32'(an),      32'b111);
    check("abort_busy", 32'(busy),    32'd0);
    check("abort_dig",  32'(dut.dig), 32'd0);
    tick(2);
    rs = 1'b1;
    tick(1);
    check("restart_busy", 32'(busy), 32'd1);
    wait_idle("restart");
    check("restart_dig", 32'(dut.dig), 32'(exp_dig(200)));
    check_display(200, "v200");

    // Random values, each different from the one before.
    prev = 8'd200;
    for (int r = 0; r < 8; r++) begin
      v = 8'($urandom_range(0, 255));
      if (v == prev) v = v + 8'd1;
      convert(v, $sformatf("rnd%0d", r));
      check_display(int'(v), $sformatf("rnd%0d", r));
      prev = v;
    end

    // Counter-style stepping through the 255 -> 0 wrap.
    cvals = '{254, 255, 0, 1};
    for (int k = 0; k < 4; k++) begin
      dem8_bit = 8'(cvals[k]);
      tick(19);
      check($sformatf("cnt_dig_%0d", cvals[k]), 32'(dut.dig), 32'(exp_dig(cvals[k])));
      check($sformatf("cnt_busy_%0d", cvals[k]), 32'(busy), 32'd0);
      tick(1);
    end
    check_display(1, "cnt_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_count_display.md
# seg7_count_display

Downstream display stage for the 8-bit up/down counter. It takes the counter's `dem8_bit` value and converts it to three BCD digits with a sequential double-dabble. It then drives a 3-digit, common-anode, time-multiplexed 7-segment display from `clk50m`. It has no handshake with the counter: it watches the bus and reconverts whenever the value changes.

## Interface
- `SCAN_DIV`, default 50000: clocks per digit slot; 1 kHz per digit at 50 MHz. Legal range is ≥2.
- `clk50m`  in  1  system clock, 50 MHz.
- `rs`  in  1  reset, asynchronous, active-low.
- `dem8_bit`  in  8  unsigned binary value from the counter, 0..255.
- `seg`  out  7  segment drive, active-low; `seg[0]`=a … `seg[6]`=g.
- `an`  out  3  digit enable, active-low; `an[0]`=units, `an[1]`=tens, `an[2]`=hundreds.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- Registers:
  - `last_bin[7:0]`: last converted value.
  - `sh[19:0]`: double-dabble shift register, `{hund[3:0], tens[3:0], units[3:0], bin[7:0]}`.
  - `bit_cnt[3:0]`: shift counter.
  - `dig[2:0][3:0]`: displayed BCD digits.
  - `div_cnt`: scan divider, width `$clog2(SCAN_DIV)`.
  - `idx[1:0]`: current digit slot.
- Converter FSM states: IDLE, SHIFT, UPDATE.
  - IDLE: if `dem8_bit != last_bin`, load `sh = {12'd0, dem8_bit}`, set `bit_cnt=0`, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift `sh` left by 1. This is one combined step per clock. After 8 steps (`bit_cnt==7`), go to UPDATE.
  - UPDATE: write the BCD nibbles to `dig`, copy the latched binary into `last_bin`, return to IDLE.
  - `busy` = (state != IDLE).
- `dem8_bit` changes during SHIFT or UPDATE are ignored. IDLE compares again on return, so the display always converges to the current input.
- Scanner:
  - `div_cnt` counts 0..SCAN_DIV-1 and wraps.
  - On wrap, `idx` advances 0→1→2→0. The value 3 is never reached; if it occurs, force `idx` to 0.
- Output register, updated every clock:
  - `an` = one-hot-low of `idx`.
  - `seg` = pattern of `dig[idx]`.
  - Patterns for nibble 0..9 are standard. Nibbles 10..15 (unreachable) give blank, `7'h7F`.

## Timing
- Reset values:
  - state IDLE; `last_bin`=0, `dig`=0, `sh`=0, `bit_cnt`=0, `div_cnt`=0, `idx`=0.
  - `seg`=`7'h7F`, `an`=`3'b111`, `busy`=0.
- Outputs become active on the first clock after `rs` deasserts.
- Latency: new value sampled in IDLE at edge N.
  - `busy` high from N+1.
  - `dig` updated at edge N+9.
  - `seg`/`an` reflect the new value at N+10, if that digit is selected.
- Minimum spacing between conversions: 10 clocks.
- Reset asserted mid-conversion: immediate abort to the reset values. After release, IDLE compares against `last_bin=0` and reconverts if the input is nonzero.
- Boundary values:
  - 0 converts to 0,0,0.
  - 255 converts to 2,5,5.
  - Wrap from 255 to 0 in the counter needs no special handling.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Hundreds digit blanks (`7'h7F`, `an` still driven) when it is 0.
  - Tens digit blanks when both hundreds and tens are 0.
  - Units digit is never blanked.
- `LEADING_ZERO_BLANK_EN` undefined: all three digits are always shown (e.g. "007").

## Structure
- Package `seg7_pkg`:
  - converter state enum `{S_IDLE, S_SHIFT, S_UPDATE}`.
  - constants `SEG_BLANK = 7'h7F` and `SEG_OFF_AN = 3'b111`.
  - function `bcd_to_seg(input [3:0]) -> [6:0]` (active-low patterns).
- Sub-module `bin2bcd_seq`:
  - Ports: `clk50m`, `rs`, `start`, `bin[7:0]`, `done`, `bcd[11:0]`.
  - Holds the FSM shift datapath. The top level holds the compare logic, scanner and output register.

## Test plan
- Reset with `dem8_bit`=0 and `SCAN_DIV`=4 → `seg`=`7'h7F`, `an`=`3'b111` during reset. After release, `an` cycles 110→101→011, each slot 4 clocks. `seg` = "0" pattern (`7'h40`) on every digit, or blank on tens/hundreds with `LEADING_ZERO_BLANK_EN`.
- `dem8_bit`=255 → `busy` high for exactly 9 clocks; `dig`={2,5,5}; `seg` = `7'h24` (2), `7'h12` (5), `7'h12` (5) on hundreds/tens/units.
- `dem8_bit`=7, with and without `LEADING_ZERO_BLANK_EN` → "007" vs "  7"; units `seg`=`7'h78`.
- `dem8_bit` 100→101 on the 3rd cycle of `busy` → first conversion completes with {1,0,0}, then a second conversion starts the cycle after UPDATE and ends at {1,0,1}.
- `rs` pulsed low mid-SHIFT while converting 200 → all outputs return to reset values immediately. After release, conversion restarts and ends at {2,0,0}.
- Counter-driven run: `dem8_bit` stepping 254,255,0,1 every 20 clocks → `dig` tracks {2,5,4},{2,5,5},{0,0,0},{0,0,1}, with no missed values.
